// File: rtl/cf_math_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cf_math_pkg
// Description : Small elaboration-time math helpers shared across IP blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cf_math_pkg;

  // Integer ceiling division; a non-positive divisor yields 1 so that widths
  // derived from it stay legal long enough for the parameter checks to fire.
  function automatic int ceil_div(input int dividend, input int divisor);
    if (divisor <= 0) begin
      return 1;
    end
    return (dividend + divisor - 1) / divisor;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and parameter checks for the multi-port SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Intended power-up state of the storage array.
  typedef enum logic {
    INIT_X    = 1'b0,
    INIT_ZERO = 1'b1
  } sram_init_e;

  // Returns 1 when the parameter set describes a buildable memory.
  function automatic bit check_sram_params(
    input int         num_ports,
    input int         latency,
    input int         data_width,
    input int         byte_width,
    input sram_init_e init
  );
    bit ok;
    ok = (num_ports >= 1) && (latency >= 1) && (data_width >= 1) && (byte_width >= 1);
    if (ok) begin
      ok = ((data_width % byte_width) == 0);
    end
    ok = ok && ((init == INIT_X) || (init == INIT_ZERO));
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_pipe
// Description : Per-port read pipeline. A LATENCY-deep shift register of
//               {valid, data}; data stages only load when the stage behind
//               them is valid, so the output word holds between results.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_pipe #(
  parameter int LATENCY    = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [LATENCY-1:0]    r_valid;
  logic [DATA_WIDTH-1:0] r_data [LATENCY];

  // Shift valid every cycle; move data only alongside a valid token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        if (r_valid[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/sram_multiport.sv
`default_nettype none
// ============================================================================
// Module      : sram_multiport
// Description : N-port behavioural SRAM with byte-lane writes, per-lane
//               lowest-port-wins collision merge, read-first semantics and a
//               configurable, reset-clearable read pipeline per port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_multiport #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter bit INIT_ZERO  = 1'b1,
  // Raise a simulation error on out-of-range accesses.
  parameter bit OOR_ERROR  = 1'b1,
  parameter int BE_WIDTH   = cf_math_pkg::ceil_div(DATA_WIDTH, BYTE_WIDTH),
  localparam int c_addr_w  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][c_addr_w-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]   be_i,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o
);

  import sram_pkg::*;

  // Contents power up as zero on FPGA block RAM and in two-state simulation;
  // INIT_ZERO records the intended state and is validated with the rest.
  localparam sram_init_e           c_init      = INIT_ZERO ? sram_pkg::INIT_ZERO : sram_pkg::INIT_X;
  localparam bit                   c_params_ok = check_sram_params(NUM_PORTS, LATENCY, DATA_WIDTH,
                                                                   BYTE_WIDTH, c_init);
  localparam logic [c_addr_w:0]    c_depth     = (c_addr_w + 1)'(NUM_WORDS);

  if (!c_params_ok) begin : g_bad_params
    $fatal(1, "sram_multiport: illegal parameters (NUM_PORTS, LATENCY >= 1, DATA_WIDTH %% BYTE_WIDTH == 0)");
  end

  logic [DATA_WIDTH-1:0]                 r_mem [NUM_WORDS];
  logic [NUM_PORTS-1:0]                  w_in_range;
  logic [NUM_PORTS-1:0]                  w_wr_en;
  logic [NUM_PORTS-1:0]                  w_rd_en;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  w_rd_word;

  // Qualify requests (ignored during reset) and fetch the pre-edge word so a
  // same-cycle write is never visible to a read (read-first).
  always_comb begin
    w_in_range = '0;
    w_wr_en    = '0;
    w_rd_en    = '0;
    w_rd_word  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_in_range[p] = ({1'b0, addr_i[p]} < c_depth);
      w_wr_en[p]    = !rst_i && req_i[p] && we_i[p] && w_in_range[p];
      w_rd_en[p]    = !rst_i && req_i[p] && !we_i[p];
      w_rd_word[p]  = w_in_range[p] ? r_mem[addr_i[p]] : '0;
    end
  end

  // Byte-lane writes; walking ports high-to-low lets the lowest port's
  // non-blocking update land last, so it wins each contested lane.
  always_ff @(posedge clk_i) begin
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (w_wr_en[p]) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be_i[p][b]) begin
            r_mem[addr_i[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[p][b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sram_rd_pipe #(
      .LATENCY    (LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_valid (w_rd_en[g]),
      .i_data  (w_rd_word[g]),
      .o_valid (rvalid_o[g]),
      .o_data  (rdata_o[g])
    );
  end

  if (OOR_ERROR) begin : g_oor_check
    // Flag accesses beyond the configured depth.
    always @(posedge clk_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!rst_i && req_i[p] && !w_in_range[p]) begin
          $error("sram_multiport: port %0d address %0d beyond depth %0d", p, addr_i[p], NUM_WORDS);
        end
      end
    end
  end

  a_req_known : assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(req_i))
    else $error("sram_multiport: req_i has unknown bits");

endmodule
`default_nettype wire

// File: tb/tb_sram_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_multiport
// Description : Three sram_multiport instances (LATENCY 1/3/2, one with a
//               1000-word depth) share one stimulus stream. A vector table
//               carries per-port operations and expected read data; reads
//               are queued with their due cycle and checked on rvalid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_multiport;

  localparam int c_lat [3] = '{1, 3, 2};
  localparam int c_nw  [3] = '{1024, 1000, 1024};
  localparam bit c_oor [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;    // expected read data, 1024-word instances
    logic [63:0] exp_s;  // expected read data, 1000-word instance
  } op_t;
  typedef op_t [1:0] vec_t;
  typedef struct { int due; logic [63:0] d; } exp_t;

  logic                  clk;
  logic                  rst;
  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0][9:0]       addr;
  logic [1:0][63:0]      wdata;
  logic [1:0][7:0]       be;
  logic [1:0][63:0]      rdata  [3];
  logic [1:0]            rvalid [3];

  int          cyc;
  int          n_cmp;
  int          n_err;
  exp_t        sb   [6][$];
  logic [63:0] last [6];
  vec_t        tbl  [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_multiport #(
      .NUM_PORTS  (2),
      .DATA_WIDTH (64),
      .BYTE_WIDTH (8),
      .NUM_WORDS  (c_nw[g]),
      .LATENCY    (c_lat[g]),
      .INIT_ZERO  (1'b1),
      .OOR_ERROR  (c_oor[g])
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .be_i     (be),
      .rdata_o  (rdata[g]),
      .rvalid_o (rvalid[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic op_t op_nop();
    return '0;
  endfunction

  function automatic op_t op_wr(logic [9:0] a, logic [63:0] d, logic [7:0] b);
    op_t o = '0;
    o.req = 1'b1; o.we = 1'b1; o.addr = a; o.wdata = d; o.be = b;
    return o;
  endfunction

  function automatic op_t op_rds(logic [9:0] a, logic [63:0] e, logic [63:0] es);
    op_t o = '0;
    o.req = 1'b1; o.addr = a; o.exp = e; o.exp_s = es;
    return o;
  endfunction

  function automatic op_t op_rd(logic [9:0] a, logic [63:0] e);
    return op_rds(a, e, e);
  endfunction

  function automatic vec_t mk(op_t o0, op_t o1);
    vec_t v;
    v[0] = o0;
    v[1] = o1;
    return v;
  endfunction

  task automatic chk(string name, int i, int p, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d port%0d cycle %0d: got %h, required %h", name, i, p, cyc, act, exp);
    end
  endtask

  // Compare every port of every instance against the scoreboard.
  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        int k;
        k = i * 2 + p;
        if (rvalid[i][p]) begin
          if (sb[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rvalid dut%0d port%0d cycle %0d: got rvalid=1, required 0", i, p, cyc);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            chk("rd_cycle", i, p, 64'(cyc), 64'(e.due));
            chk("rd_data", i, p, rdata[i][p], e.d);
          end
          last[k] = rdata[i][p];
        end else begin
          chk("rd_hold", i, p, rdata[i][p], last[k]);
          if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_rvalid dut%0d port%0d cycle %0d: got rvalid=0, required 1", i, p, cyc);
            void'(sb[k].pop_front());
          end
        end
      end
    end
  endtask

  // One clock: check outputs, then drive the next vector and queue its reads.
  task automatic step(vec_t v, bit [2:0] push_mask = 3'b111);
    @(negedge clk);
    cyc++;
    monitor();
    for (int p = 0; p < 2; p++) begin
      req[p]   = v[p].req;
      we[p]    = v[p].we;
      addr[p]  = v[p].addr;
      wdata[p] = v[p].wdata;
      be[p]    = v[p].be;
    end
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (push_mask[i] && v[p].req && !v[p].we) begin
          sb[i*2+p].push_back('{due: cyc + c_lat[i], d: (i == 1) ? v[p].exp_s : v[p].exp});
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 6; k++) last[k] = '0;

    tbl.push_back(mk(op_wr(10'h010, 64'hDEAD_BEEF_0123_4567, 8'hFF), op_nop()));
    tbl.push_back(mk(op_nop(), op_rd(10'h010, 64'hDEAD_BEEF_0123_4567)));
    tbl.push_back(mk(op_wr(10'h020, 64'h1111_1111_1111_1111, 8'h0F),
                     op_wr(10'h020, 64'h2222_2222_2222_2222, 8'hFF)));
    tbl.push_back(mk(op_rd(10'h020, 64'h2222_2222_1111_1111), op_nop()));
    tbl.push_back(mk(op_wr(10'h021, 64'h0, 8'hFF), op_nop()));
    tbl.push_back(mk(op_wr(10'h021, 64'h3333_3333_3333_3333, 8'hF0),
                     op_wr(10'h021, 64'h4444_4444_4444_4444, 8'h3C)));
    tbl.push_back(mk(op_nop(), op_rd(10'h021, 64'h3333_3333_4444_0000)));
    tbl.push_back(mk(op_nop(), op_wr(10'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00)));
    tbl.push_back(mk(op_rd(10'h010, 64'hDEAD_BEEF_0123_4567), op_nop()));
    tbl.push_back(mk(op_nop(), op_wr(10'h010, 64'h0000_0000_0000_00AB, 8'h01)));
    tbl.push_back(mk(op_rd(10'h010, 64'hDEAD_BEEF_0123_45AB), op_rd(10'h010, 64'hDEAD_BEEF_0123_45AB)));
    tbl.push_back(mk(op_wr(10'h000, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF),
                     op_wr(10'h001, 64'hB1B1_B1B1_B1B1_B1B1, 8'hFF)));
    tbl.push_back(mk(op_wr(10'h002, 64'hC2C2_C2C2_C2C2_C2C2, 8'hFF), op_nop()));
    tbl.push_back(mk(op_rd(10'h000, 64'hA0A0_A0A0_A0A0_A0A0), op_nop()));
    tbl.push_back(mk(op_rd(10'h001, 64'hB1B1_B1B1_B1B1_B1B1), op_nop()));
    tbl.push_back(mk(op_rd(10'h002, 64'hC2C2_C2C2_C2C2_C2C2), op_nop()));
    for (int n = 0; n < 3; n++) tbl.push_back(mk(op_nop(), op_nop()));
    tbl.push_back(mk(op_wr(10'd5, 64'h0505_0505_0505_0505, 8'hFF), op_nop()));
    tbl.push_back(mk(op_wr(10'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF), op_rd(10'd5, 64'h0505_0505_0505_0505)));
    tbl.push_back(mk(op_nop(), op_rd(10'd5, 64'hAAAA_AAAA_AAAA_AAAA)));
    tbl.push_back(mk(op_wr(10'd1010, 64'h7777_7777_7777_7777, 8'hFF),
                     op_wr(10'd999, 64'h9999_9999_9999_9999, 8'hFF)));
    tbl.push_back(mk(op_rd(10'd999, 64'h9999_9999_9999_9999),
                     op_rds(10'd1010, 64'h7777_7777_7777_7777, 64'h0)));
    tbl.push_back(mk(op_rd(10'h010, 64'hDEAD_BEEF_0123_45AB),
                     op_wr(10'h010, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF)));
    tbl.push_back(mk(op_rd(10'h010, 64'h5A5A_5A5A_5A5A_5A5A), op_nop()));
    for (int n = 0; n < 5; n++) tbl.push_back(mk(op_nop(), op_nop()));

    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        chk("reset_rvalid", i, p, 64'(rvalid[i][p]), 64'd0);
        chk("reset_rdata", i, p, rdata[i][p], 64'd0);
      end
    end
    rst = 1'b0;
    cyc = 0;

    foreach (tbl[n]) step(tbl[n]);

    // Reset with reads in flight: only the LATENCY=1 instance completes first.
    step(mk(op_rd(10'd5, 64'hAAAA_AAAA_AAAA_AAAA), op_nop()), 3'b001);
    step(mk(op_wr(10'd5, 64'h5555_5555_5555_5555, 8'hFF), op_rd(10'd5, 64'h0)), 3'b000);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        chk("async_rst_rvalid", i, p, 64'(rvalid[i][p]), 64'd0);
        chk("async_rst_rdata", i, p, rdata[i][p], 64'd0);
        last[i*2+p] = '0;
      end
    end
    step(mk(op_nop(), op_nop()));
    rst = 1'b0;
    repeat (2) step(mk(op_nop(), op_nop()));
    step(mk(op_nop(), op_rd(10'd5, 64'hAAAA_AAAA_AAAA_AAAA)));
    step(mk(op_rd(10'h021, 64'h3333_3333_4444_0000), op_rd(10'h020, 64'h2222_2222_1111_1111)));
    repeat (6) step(mk(op_nop(), op_nop()));

    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (sb[k].size() != 0) begin
        n_err++;
        $display("FAIL drain dut%0d port%0d: got %0d pending reads, required 0", k / 2, k % 2, sb[k].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
